// File: rtl/bpred_pc_gen_pkg.sv
// rtl/bpred_pc_gen_pkg.sv - shared opcodes, link registers, immediate extraction and predecode
// Purpose: constants and helpers used by the fetch PC generator and its BHT.
// Ports: none (package).
package bpred_pc_gen_pkg;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_B_TYPE = 7'b1100011;

   localparam logic [4:0] REG_X0 = 5'd0;
   localparam logic [4:0] REG_X1 = 5'd1;
   localparam logic [4:0] REG_X5 = 5'd5;

   localparam logic [1:0] BHT_INIT = 2'b01;

   typedef struct packed {
      logic jal;
      logic bxx;
      logic call;
      logic ret;
   } predec_t;

   function automatic logic is_link(input logic [4:0] r);
      return (r == REG_X1) || (r == REG_X5);
   endfunction

   // J-type immediate, sign-extended to 32 bits, bit 0 forced to zero
   function automatic logic [31:0] imm_j(input logic [31:0] ir);
      return {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
   endfunction

   // B-type immediate, sign-extended to 32 bits, bit 0 forced to zero
   function automatic logic [31:0] imm_b(input logic [31:0] ir);
      return {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
   endfunction

   function automatic predec_t predecode(input logic valid, input logic [31:0] ir);
      predec_t    p;
      logic [6:0] opc;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic       jalr;
      opc    = ir[6:0];
      rd     = ir[11:7];
      rs1    = ir[19:15];
      jalr   = valid && (opc == OPC_JALR);
      p.jal  = valid && (opc == OPC_JAL);
      p.bxx  = valid && (opc == OPC_B_TYPE);
      p.call = (p.jal || jalr) && is_link(rd);
      // A plain return (rd = x0), or the coroutine swap (rd and rs1 both
      // link registers but different), which also counts as a call.
      p.ret  = jalr && is_link(rs1) && (ir[31:20] == 12'd0) &&
               ((rd == REG_X0) || (is_link(rd) && (rd != rs1)));
      return p;
   endfunction

endpackage

// File: rtl/bpred_pc_gen_if.sv
// rtl/bpred_pc_gen_if.sv - fetch PC generator handshake/redirect bundle
// Purpose: groups the stall, instruction, redirect and prediction signals.
// Ports (master drives): stall, instr_valid, instr, id_redirect, id_target,
//   ex_resolve, ex_pc, ex_taken, ex_mispredict, ex_target.
// Ports (slave drives): pc, pc_next, take, instr_nop_sel.
interface bpred_pc_gen_if #(
   parameter int unsigned PC_SIZE = 32
);
   logic               stall;
   logic               instr_valid;
   logic [31:0]        instr;
   logic               id_redirect;
   logic [PC_SIZE-1:0] id_target;
   logic               ex_resolve;
   logic [PC_SIZE-1:0] ex_pc;
   logic               ex_taken;
   logic               ex_mispredict;
   logic [PC_SIZE-1:0] ex_target;
   logic [PC_SIZE-1:0] pc;
   logic [PC_SIZE-1:0] pc_next;
   logic               take;
   logic               instr_nop_sel;

   modport master (
      output stall, instr_valid, instr, id_redirect, id_target,
             ex_resolve, ex_pc, ex_taken, ex_mispredict, ex_target,
      input  pc, pc_next, take, instr_nop_sel
   );

   modport slave (
      input  stall, instr_valid, instr, id_redirect, id_target,
             ex_resolve, ex_pc, ex_taken, ex_mispredict, ex_target,
      output pc, pc_next, take, instr_nop_sel
   );
endinterface

// File: rtl/bpred_pc_gen_bht.sv
// rtl/bpred_pc_gen_bht.sv - bimodal table of 2-bit saturating counters
// Purpose: read port gives the prediction bit; update port trains one counter.
// Ports: clk, rst_n, rd_idx_i (read index), rd_taken_o (counter MSB),
//   upd_i / upd_idx_i / upd_taken_i (resolved branch training).
module bpred_bht
   import bpred_pc_gen_pkg::*;
#(
   parameter int unsigned ENTRIES = 64
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [$clog2(ENTRIES)-1:0]  rd_idx_i,
   output logic                        rd_taken_o,
   input  logic                        upd_i,
   input  logic [$clog2(ENTRIES)-1:0]  upd_idx_i,
   input  logic                        upd_taken_i
);

   logic [1:0] ctr_q [ENTRIES];

   // Read sees the pre-update value when both hit the same entry.
   assign rd_taken_o = ctr_q[rd_idx_i][1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            ctr_q[i] <= BHT_INIT;
         end
      end else if (upd_i) begin
         if (upd_taken_i) begin
            if (ctr_q[upd_idx_i] != 2'b11) ctr_q[upd_idx_i] <= ctr_q[upd_idx_i] + 2'b01;
         end else begin
            if (ctr_q[upd_idx_i] != 2'b00) ctr_q[upd_idx_i] <= ctr_q[upd_idx_i] - 2'b01;
         end
      end
   end

endmodule

// File: rtl/bpred_pc_gen.sv
// rtl/bpred_pc_gen.sv - IF-stage fetch PC register with JAL/branch/return prediction
// Purpose: owns the fetch PC, predecodes the fetched word and selects the next PC.
// Ports: clk, rst_n (async, active low), bus (slave side of bpred_pc_gen_if):
//   stall/instr_valid/instr in, ID and EX redirects in, EX branch resolution in,
//   pc/pc_next/take/instr_nop_sel out.
module bpred_pc_gen
   import bpred_pc_gen_pkg::*;
#(
   parameter int unsigned        PC_SIZE     = 32,
   parameter logic [PC_SIZE-1:0] RESET_PC    = '0,
   parameter int unsigned        MODE        = 1,
   parameter int unsigned        BHT_ENTRIES = 64,
   parameter int unsigned        RAS_DEPTH   = 4
)(
   input logic           clk,
   input logic           rst_n,
   bpred_pc_gen_if.slave bus
);

   localparam int unsigned RAS_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned RAS_CNT_W = $clog2(RAS_DEPTH + 1);

   function automatic logic [RAS_PTR_W-1:0] ptr_inc(input logic [RAS_PTR_W-1:0] p);
      return (p == RAS_PTR_W'(RAS_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [RAS_PTR_W-1:0] ptr_dec(input logic [RAS_PTR_W-1:0] p);
      return (p == '0) ? RAS_PTR_W'(RAS_DEPTH - 1) : p - 1'b1;
   endfunction

   logic [PC_SIZE-1:0]   pc_q, pc_d;
   logic [PC_SIZE-1:0]   pc_plus4, jal_tgt, br_tgt, ras_top;
   logic [PC_SIZE-1:0]   ras_q [RAS_DEPTH];
   logic [RAS_PTR_W-1:0] sp_q, sp_top;   // sp_q is the next free slot
   logic [RAS_CNT_W-1:0] cnt_q;
   predec_t              pd;
   logic                 take, nop_sel, ras_en, ras_hit;

   assign pd       = predecode(bus.instr_valid, bus.instr);
   assign pc_plus4 = pc_q + PC_SIZE'(4);
   assign jal_tgt  = pc_q + PC_SIZE'($signed(imm_j(bus.instr)));
   assign br_tgt   = pc_q + PC_SIZE'($signed(imm_b(bus.instr)));
   assign nop_sel  = bus.ex_mispredict | bus.id_redirect;
   assign sp_top   = ptr_dec(sp_q);
   assign ras_top  = ras_q[sp_top];
   assign ras_hit  = pd.ret && (cnt_q != '0);
   assign ras_en   = bus.instr_valid & ~bus.stall & ~nop_sel;

   generate
      if (MODE == 1) begin : g_bht
         localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
         logic bht_taken;
         bpred_bht #(.ENTRIES(BHT_ENTRIES)) u_bht (
            .clk         (clk),
            .rst_n       (rst_n),
            .rd_idx_i    (pc_q[IDX_W+1:2]),
            .rd_taken_o  (bht_taken),
            .upd_i       (bus.ex_resolve),
            .upd_idx_i   (bus.ex_pc[IDX_W+1:2]),
            .upd_taken_i (bus.ex_taken)
         );
         assign take = pd.bxx & bht_taken;
      end else begin : g_static
         // Backward branches (negative offset) predicted taken.
         assign take = pd.bxx & bus.instr[31];
      end
   endgenerate

   always_comb begin
      pc_d = pc_plus4;
      if (bus.ex_mispredict)    pc_d = bus.ex_target;
      else if (bus.id_redirect) pc_d = bus.id_target;
      else if (bus.stall)       pc_d = pc_q;
      else if (pd.jal)          pc_d = jal_tgt;
      else if (take)            pc_d = br_tgt;
      else if (ras_hit)         pc_d = ras_top;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   // Circular return stack: a push when full overwrites the oldest entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < int'(RAS_DEPTH); i++) begin
            ras_q[i] <= '0;
         end
      end else if (ras_en) begin
         if (pd.call && pd.ret) begin
            if (cnt_q == '0) begin
               ras_q[sp_q] <= pc_plus4;
               sp_q        <= ptr_inc(sp_q);
               cnt_q       <= RAS_CNT_W'(1);
            end else begin
               ras_q[sp_top] <= pc_plus4;
            end
         end else if (pd.call) begin
            ras_q[sp_q] <= pc_plus4;
            sp_q        <= ptr_inc(sp_q);
            if (cnt_q != RAS_CNT_W'(RAS_DEPTH)) cnt_q <= cnt_q + 1'b1;
         end else if (ras_hit) begin
            sp_q  <= sp_top;
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   assign bus.pc            = pc_q;
   assign bus.pc_next       = pc_d;
   assign bus.take          = take;
   assign bus.instr_nop_sel = nop_sel;

endmodule

// File: tb/tb_bpred_pc_gen.sv
// tb/tb_bpred_pc_gen.sv - vector table and scoreboard bench for bpred_pc_gen
module tb_bpred_pc_gen;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] JAL1 = 32'h1000_00EF;  // jal x1, +0x100
   localparam logic [31:0] RET  = 32'h0000_8067;  // jalr x0, 0(x1)
   localparam logic [31:0] BEQM = 32'hFE00_0CE3;  // beq x0, x0, -8
   localparam logic [31:0] BEQP = 32'h0000_0463;  // beq x0, x0, +8

   typedef struct {
      logic        sel0;
      logic        stall;
      logic        iv;
      logic [31:0] instr;
      logic        idr;
      logic [31:0] idt;
      logic        exm;
      logic [31:0] ext;
      logic        exr;
      logic [31:0] expc;
      logic        extk;
      logic [31:0] e_pc;
      logic [31:0] e_next;
      logic        e_take;
      logic        e_nop;
   } vec_t;

   typedef struct {
      int          id;
      logic        sel0;
      logic [31:0] pc;
      logic [31:0] nxt;
      logic        take;
      logic        nop;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   exp_t sbq[$];
   vec_t vt[$];

   bpred_pc_gen_if #(.PC_SIZE(32)) bus1 ();
   bpred_pc_gen_if #(.PC_SIZE(32)) bus0 ();

   assign bus0.stall         = bus1.stall;
   assign bus0.instr_valid   = bus1.instr_valid;
   assign bus0.instr         = bus1.instr;
   assign bus0.id_redirect   = bus1.id_redirect;
   assign bus0.id_target     = bus1.id_target;
   assign bus0.ex_resolve    = bus1.ex_resolve;
   assign bus0.ex_pc         = bus1.ex_pc;
   assign bus0.ex_taken      = bus1.ex_taken;
   assign bus0.ex_mispredict = bus1.ex_mispredict;
   assign bus0.ex_target     = bus1.ex_target;

   bpred_pc_gen #(.PC_SIZE(32), .RESET_PC(32'h100), .MODE(1), .BHT_ENTRIES(64), .RAS_DEPTH(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1));
   bpred_pc_gen #(.PC_SIZE(32), .RESET_PC(32'h100), .MODE(0), .BHT_ENTRIES(64), .RAS_DEPTH(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL v%0d %0s: got %h expected %h", id, nm, act, exp);
      end
   endtask

   // Scoreboard side: pop one expectation per cycle at the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         if (e.sel0) begin
            chk("pc0",      e.id, bus0.pc,                    e.pc);
            chk("pc_next0", e.id, bus0.pc_next,               e.nxt);
            chk("take0",    e.id, {31'd0, bus0.take},          {31'd0, e.take});
            chk("nop0",     e.id, {31'd0, bus0.instr_nop_sel}, {31'd0, e.nop});
         end else begin
            chk("pc",       e.id, bus1.pc,                    e.pc);
            chk("pc_next",  e.id, bus1.pc_next,               e.nxt);
            chk("take",     e.id, {31'd0, bus1.take},          {31'd0, e.take});
            chk("nop",      e.id, {31'd0, bus1.instr_nop_sel}, {31'd0, e.nop});
         end
      end
   end

   function automatic vec_t f_ins(input logic [31:0] ins, input logic [31:0] pc,
                                  input logic [31:0] nxt, input logic tk);
      vec_t t;
      t = '{default: '0};
      t.iv = 1'b1; t.instr = ins; t.e_pc = pc; t.e_next = nxt; t.e_take = tk;
      return t;
   endfunction

   function automatic vec_t f_redir(input logic [31:0] tgt, input logic [31:0] pc);
      vec_t t;
      t = '{default: '0};
      t.exm = 1'b1; t.ext = tgt; t.e_pc = pc; t.e_next = tgt; t.e_nop = 1'b1;
      return t;
   endfunction

   // beq at 0x40 while training the counter at 0x40
   function automatic vec_t f_bht(input logic st, input logic exr, input logic tk_act,
                                  input logic [31:0] nxt, input logic tk_exp);
      vec_t t;
      t = f_ins(BEQP, 32'h40, nxt, tk_exp);
      t.stall = st; t.exr = exr; t.expc = 32'h40; t.extk = tk_act;
      return t;
   endfunction

   task automatic apply(input vec_t t, input int id);
      bus1.stall         = t.stall;
      bus1.instr_valid   = t.iv;
      bus1.instr         = t.instr;
      bus1.id_redirect   = t.idr;
      bus1.id_target     = t.idt;
      bus1.ex_mispredict = t.exm;
      bus1.ex_target     = t.ext;
      bus1.ex_resolve    = t.exr;
      bus1.ex_pc         = t.expc;
      bus1.ex_taken      = t.extk;
      sbq.push_back('{id, t.sel0, t.e_pc, t.e_next, t.e_take, t.e_nop});
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t t;
      apply_idle();
      rst_n = 1'b0;

      // Table
      vt.push_back(f_ins(NOP, 32'h100, 32'h104, 1'b0));
      vt.push_back(f_ins(NOP, 32'h104, 32'h108, 1'b0));
      vt.push_back(f_redir(32'h200, 32'h108));
      t = f_ins(BEQM, 32'h200, 32'h1F8, 1'b1); t.sel0 = 1'b1; vt.push_back(t);
      t = f_redir(32'h200, 32'h1F8);           t.sel0 = 1'b1; vt.push_back(t);
      t = f_ins(BEQP, 32'h200, 32'h204, 1'b0); t.sel0 = 1'b1; vt.push_back(t);
      vt.push_back(f_redir(32'h40, 32'h204));
      vt.push_back(f_bht(1'b1, 1'b1, 1'b1, 32'h40, 1'b0));  // 01 read, ->10
      vt.push_back(f_bht(1'b1, 1'b1, 1'b1, 32'h40, 1'b1));  // 10, ->11
      vt.push_back(f_bht(1'b1, 1'b1, 1'b1, 32'h40, 1'b1));  // 11, stays 11
      vt.push_back(f_bht(1'b1, 1'b1, 1'b0, 32'h40, 1'b1));  // 11, ->10
      vt.push_back(f_bht(1'b1, 1'b1, 1'b0, 32'h40, 1'b1));  // 10, ->01
      vt.push_back(f_bht(1'b1, 1'b1, 1'b0, 32'h40, 1'b0));  // 01, ->00
      vt.push_back(f_bht(1'b1, 1'b1, 1'b0, 32'h40, 1'b0));  // 00, stays 00
      vt.push_back(f_bht(1'b1, 1'b1, 1'b1, 32'h40, 1'b0));  // 00, ->01
      vt.push_back(f_bht(1'b0, 1'b0, 1'b0, 32'h44, 1'b0));  // 01, not taken
      vt.push_back(f_redir(32'h300, 32'h44));
      vt.push_back(f_ins(JAL1, 32'h300, 32'h400, 1'b0));
      vt.push_back(f_ins(RET,  32'h400, 32'h304, 1'b0));
      vt.push_back(f_ins(RET,  32'h304, 32'h308, 1'b0));
      vt.push_back(f_redir(32'h1000, 32'h308));
      for (int k = 0; k < 5; k++) begin
         vt.push_back(f_ins(JAL1, 32'(32'h1000 + k * 256), 32'(32'h1100 + k * 256), 1'b0));
      end
      vt.push_back(f_ins(RET, 32'h1500, 32'h1404, 1'b0));
      vt.push_back(f_ins(RET, 32'h1404, 32'h1304, 1'b0));
      vt.push_back(f_ins(RET, 32'h1304, 32'h1204, 1'b0));
      vt.push_back(f_ins(RET, 32'h1204, 32'h1104, 1'b0));
      vt.push_back(f_ins(RET, 32'h1104, 32'h1108, 1'b0));
      t = f_ins(JAL1, 32'h1108, 32'h1108, 1'b0); t.stall = 1'b1; vt.push_back(t);
      vt.push_back(f_ins(RET, 32'h1108, 32'h110C, 1'b0));
      t = f_redir(32'hA00, 32'h110C);
      t.iv = 1'b1; t.instr = JAL1; t.idr = 1'b1; t.idt = 32'hB00; t.stall = 1'b1;
      vt.push_back(t);
      t = f_redir(32'hB00, 32'hA00);
      t.exm = 1'b0; t.ext = 32'h0; t.idr = 1'b1; t.idt = 32'hB00; t.stall = 1'b1;
      vt.push_back(t);
      vt.push_back(f_ins(RET, 32'hB00, 32'hB04, 1'b0));
      vt.push_back(f_redir(32'hFFFF_FFFC, 32'hB04));
      vt.push_back(f_ins(NOP, 32'hFFFF_FFFC, 32'h0, 1'b0));

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc",      -1, bus1.pc,      32'h100);
      chk("rst_pc0",     -1, bus0.pc,      32'h100);
      chk("rst_pc_next", -1, bus1.pc_next, 32'h104);
      chk("rst_take",    -1, {31'd0, bus1.take},          32'd0);
      chk("rst_nop",     -1, {31'd0, bus1.instr_nop_sel}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < vt.size(); i++) begin
         apply(vt[i], i);
      end

      // Mid-stream reset clears pc and the RAS
      apply(f_redir(32'h700, 32'h0), 100);
      apply(f_ins(JAL1, 32'h700, 32'h800, 1'b0), 101);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_pc",  102, bus1.pc, 32'h100);
      chk("midrst_pc0", 102, bus0.pc, 32'h100);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply(f_ins(RET, 32'h100, 32'h104, 1'b0), 103);
      apply(f_ins(NOP, 32'h104, 32'h108, 1'b0), 104);

      chk("sb_drain", 105, sbq.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   task automatic apply_idle();
      bus1.stall         = 1'b0;
      bus1.instr_valid   = 1'b0;
      bus1.instr         = '0;
      bus1.id_redirect   = 1'b0;
      bus1.id_target     = '0;
      bus1.ex_mispredict = 1'b0;
      bus1.ex_target     = '0;
      bus1.ex_resolve    = 1'b0;
      bus1.ex_pc         = '0;
      bus1.ex_taken      = 1'b0;
   endtask

endmodule
